cpu_fetch_queue: RTL and testbench

//  Parametrised instruction fetch unit with prefetch queue, for the next-generation
//  CPU core. Issues sequential fetches to a fixed-latency instruction memory and

---
 rtl/cpu_fetch_queue.sv | 107 ++++++++++
 tb/tb_cpu_fetch_queue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_fetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry prefetch queue toward decode.
// Fetch credit counts queued and in-flight words; a redirect flushes both.
module cpu_fetch_queue #(
  parameter int                INSTR_W    = 24,
  parameter int                ADDR_W     = 24,
  parameter int                DEPTH      = 4,
  parameter int                MEM_LAT    = 1,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clk_en,
  output logic               o_ireq,
  output logic [ADDR_W-1:0]  o_iaddr,
  input  logic [INSTR_W-1:0] i_instr,
  output logic               o_valid,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  input  logic               i_ready,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = CW + 4;
  localparam logic [SW-1:0]     DEPTH_S = SW'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0]  pc_q;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;
  logic [MEM_LAT-1:0] trk_v;
  logic [ADDR_W-1:0]  trk_pc [MEM_LAT];
  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0]  q_pc [DEPTH];

  logic          pop;
  logic          push;
  logic          credit_ok;
  logic [SW-1:0] inflight;
  logic [SW-1:0] used;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + {{(SW-1){1'b0}}, trk_v[i]};
    end
  end

  assign o_valid = (count != '0);
  assign o_instr = q_instr[rd_ptr];
  assign o_pc    = q_pc[rd_ptr];
  assign o_iaddr = pc_q;

  assign pop  = o_valid & i_ready & ~i_redirect & i_clk_en;
  assign push = trk_v[MEM_LAT-1] & ~i_redirect;

  // pop implies count >= 1, so the subtraction cannot underflow
  assign used      = {{(SW-CW){1'b0}}, count} + inflight - {{(SW-1){1'b0}}, pop};
  assign credit_ok = (used < DEPTH_S);
  assign o_ireq    = i_clk_en & ~i_rst & ~i_redirect & credit_ok;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc_q   <= RESET_ADDR;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      trk_v  <= '0;
    end else if (i_clk_en) begin
      if (i_redirect) begin
        pc_q   <= i_redirect_addr;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        trk_v  <= '0;
      end else begin
        if (o_ireq) pc_q <= pc_q + PC_ONE;
        trk_v[0] <= o_ireq;
        for (int i = 1; i < MEM_LAT; i++) begin
          trk_v[i] <= trk_v[i-1];
        end
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        if (push && !pop)      count <= count + CW'(1);
        else if (pop && !push) count <= count - CW'(1);
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by trk_v and count.
  always_ff @(posedge i_clk) begin
    if (!i_rst && i_clk_en) begin
      trk_pc[0] <= pc_q;
      for (int i = 1; i < MEM_LAT; i++) begin
        trk_pc[i] <= trk_pc[i-1];
      end
      if (push) begin
        q_instr[wr_ptr] <= i_instr;
        q_pc[wr_ptr]    <= trk_pc[MEM_LAT-1];
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch_queue.sv
// Directed bench for cpu_fetch_queue: three parameter sets driven from one stimulus
// thread, each backed by a fixed-latency memory returning addr + 0x100.
module tb_cpu_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        clk_en;
  logic        ready;
  logic        redirect;
  logic [23:0] redirect_addr;

  logic        a_ireq, a_valid;
  logic [23:0] a_iaddr, a_instr, a_oinstr, a_pc;
  logic        b_ireq, b_valid;
  logic [3:0]  b_iaddr, b_pc;
  logic [23:0] b_instr, b_oinstr;
  logic        c_ireq, c_valid;
  logic [23:0] c_iaddr, c_instr, c_oinstr, c_pc;

  cpu_fetch_queue dut_a (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .o_ireq(a_ireq), .o_iaddr(a_iaddr), .i_instr(a_instr),
    .o_valid(a_valid), .o_instr(a_oinstr), .o_pc(a_pc),
    .i_ready(ready), .i_redirect(redirect), .i_redirect_addr(redirect_addr)
  );

  cpu_fetch_queue #(.ADDR_W(4), .RESET_ADDR(4'hE)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .o_ireq(b_ireq), .o_iaddr(b_iaddr), .i_instr(b_instr),
    .o_valid(b_valid), .o_instr(b_oinstr), .o_pc(b_pc),
    .i_ready(ready), .i_redirect(redirect), .i_redirect_addr(redirect_addr[3:0])
  );

  cpu_fetch_queue #(.MEM_LAT(3)) dut_c (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .o_ireq(c_ireq), .o_iaddr(c_iaddr), .i_instr(c_instr),
    .o_valid(c_valid), .o_instr(c_oinstr), .o_pc(c_pc),
    .i_ready(ready), .i_redirect(redirect), .i_redirect_addr(redirect_addr)
  );

  // memory models: address pipelines advance only on enabled cycles
  logic [23:0] ma;
  logic [3:0]  mb;
  logic [23:0] mc0, mc1, mc2;
  always @(posedge clk) begin
    if (clk_en) begin
      ma  <= a_iaddr;
      mb  <= b_iaddr;
      mc0 <= c_iaddr;
      mc1 <= mc0;
      mc2 <= mc1;
    end
  end
  assign a_instr = ma + 24'h100;
  assign b_instr = {20'h0, mb} + 24'h100;
  assign c_instr = mc2 + 24'h100;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  // leaves the bench inside the first cycle after reset release
  task automatic do_reset;
    rst = 1'b1;
    clk_en = 1'b1;
    redirect = 1'b0;
    next;
    next;
    #1;
    chk("rst_valid", a_valid, 0);
    chk("rst_ireq", a_ireq, 0);
    rst = 1'b0;
    #1;
  endtask

  int exp_pop, exp_req;

  initial begin
    rst = 1'b1; clk_en = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_addr = '0;

    // T1 streaming from reset, then T3 redirect at head pc 5
    ready = 1'b1;
    do_reset;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) next;
      #1;
      chk("t1_ireq", a_ireq, 1);
      chk("t1_iaddr", a_iaddr, k);
      chk("t1_valid", a_valid, (k >= 2));
      if (k >= 2) begin
        chk("t1_pc", a_pc, k - 2);
        chk("t1_instr", a_oinstr, k - 2 + 'h100);
      end
    end
    next;
    redirect = 1'b1; redirect_addr = 24'h40;
    #1;
    chk("t3_redir_ireq", a_ireq, 0);
    chk("t3_redir_head", a_pc, 5);
    next; redirect = 1'b0; #1;
    chk("t3_flush_valid", a_valid, 0);
    chk("t3_new_ireq", a_ireq, 1);
    chk("t3_new_iaddr", a_iaddr, 'h40);
    next; #1;
    chk("t3_valid_gap", a_valid, 0);
    chk("t3_iaddr2", a_iaddr, 'h41);
    next; #1;
    chk("t3_valid_new", a_valid, 1);
    chk("t3_pc_new", a_pc, 'h40);
    chk("t3_instr_new", a_oinstr, 'h140);
    next; #1;
    chk("t3_pc_next", a_pc, 'h41);
    // back-to-back redirects: last one wins
    next; redirect = 1'b1; redirect_addr = 24'h10; #1;
    next; redirect_addr = 24'h20; #1;
    next; redirect = 1'b0; #1;
    chk("b2b_iaddr", a_iaddr, 'h20);
    chk("b2b_valid", a_valid, 0);
    next; next; #1;
    chk("b2b_pc", a_pc, 'h20);
    chk("b2b_valid2", a_valid, 1);

    // T2 decode stall fills the queue, then drains with no fetch gap
    ready = 1'b0;
    do_reset;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) next;
      #1;
      chk("t2_ireq", a_ireq, (k < 4));
      if (k < 4) chk("t2_iaddr", a_iaddr, k);
      chk("t2_valid", a_valid, (k >= 2));
    end
    for (int k = 8; k < 14; k++) begin
      next;
      ready = 1'b1;
      #1;
      chk("t2_res_ireq", a_ireq, 1);
      chk("t2_res_iaddr", a_iaddr, 4 + k - 8);
      chk("t2_res_pc", a_pc, k - 8);
    end

    // T6 50% clock enable: same sequence, stretched
    ready = 1'b1;
    do_reset;
    exp_pop = 0; exp_req = 0;
    for (int j = 0; j < 20; j++) begin
      if (j > 0) next;
      clk_en = (j % 2 == 0);
      #1;
      if (clk_en) begin
        if (a_ireq) begin
          chk("t6_iaddr", a_iaddr, exp_req);
          exp_req++;
        end
        if (a_valid) begin
          chk("t6_pc", a_pc, exp_pop);
          chk("t6_instr", a_oinstr, exp_pop + 'h100);
          exp_pop++;
        end
      end else begin
        chk("t6_ireq_off", a_ireq, 0);
      end
    end
    clk_en = 1'b1;
    chk("t6_pops", exp_pop, 8);
    chk("t6_reqs", exp_req, 10);

    // T4 address wrap with ADDR_W=4 from 0xE
    ready = 1'b1;
    do_reset;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) next;
      #1;
      chk("t4_iaddr", b_iaddr, (14 + k) % 16);
      chk("t4_valid", b_valid, (k >= 2));
      if (k >= 2) begin
        chk("t4_pc", b_pc, (12 + k) % 16);
        chk("t4_instr", b_oinstr, (12 + k) % 16 + 'h100);
      end
    end

    // T5 MEM_LAT=3: sustained rate, then redirect drops three in flight
    ready = 1'b1;
    do_reset;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) next;
      #1;
      chk("t5_ireq", c_ireq, 1);
      chk("t5_iaddr", c_iaddr, k);
      chk("t5_valid", c_valid, (k >= 4));
      if (k >= 4) chk("t5_pc", c_pc, k - 4);
    end
    next;
    redirect = 1'b1; redirect_addr = 24'h80;
    #1;
    chk("t5_redir_ireq", c_ireq, 0);
    chk("t5_redir_head", c_pc, 6);
    for (int j = 1; j <= 5; j++) begin
      next;
      redirect = 1'b0;
      #1;
      chk("t5_new_ireq", c_ireq, 1);
      chk("t5_new_iaddr", c_iaddr, 'h80 + j - 1);
      chk("t5_new_valid", c_valid, (j == 5));
      if (j == 5) begin
        chk("t5_new_pc", c_pc, 'h80);
        chk("t5_new_instr", c_oinstr, 'h180);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
